// File: rtl/mips_tag_pkg.sv
// Shared rename-tag definitions for dispatch, tag pool and reorder buffer.
// Tag width, pool size and the tag type live here.
package mips_tag_pkg;
  localparam int TAG_W    = 5;
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int CNT_W    = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/tag_ptr_ctr.sv
// Wrap-around pointer counter for the tag pool.
// Increments by one when enabled; wraps naturally at 2**W.
module tag_ptr_ctr #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/tag_fifo.sv
// Free rename-tag pool: FWFT circular FIFO preloaded with every tag.
// Optional same-cycle empty bypass enabled by defining TAG_FIFO_BYPASS_EN.
module tag_fifo
  import mips_tag_pkg::*;
#(
  parameter int TAG_W_P = TAG_W,
  parameter int DEPTH   = NUM_TAGS,
  parameter int CNT_W_P = CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Tag_rd_en,
  output logic [TAG_W_P-1:0] Tag_out,
  output logic               Tag_valid,
  input  logic               Tag_wr_en,
  input  logic [TAG_W_P-1:0] Tag_in,
  output logic               Full,
  output logic               Empty,
  output logic [CNT_W_P-1:0] Count,
  output logic               Ovf_err,
  output logic               Unf_err
);
  logic [TAG_W_P-1:0] mem_q [DEPTH];
  logic [TAG_W_P-1:0] rd_ptr, wr_ptr;
  logic [CNT_W_P-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               byp, byp_take;
  logic               pop_ok, push_ok;

  assign Full  = (count_q == CNT_W_P'(DEPTH));
  assign Empty = (count_q == '0);
  assign Count = count_q;
  assign Ovf_err = ovf_q;
  assign Unf_err = unf_q;

  always_comb begin
    byp = 1'b0;
`ifdef TAG_FIFO_BYPASS_EN
    byp = Empty & Tag_wr_en;
`endif
    byp_take  = byp & Tag_rd_en;
    Tag_valid = ~Empty | byp;
    Tag_out   = byp ? Tag_in : mem_q[rd_ptr];
  end

  // A bypassed tag is consumed in flight and never touches storage.
  always_comb begin
    pop_ok  = Tag_rd_en & ~Empty;
    push_ok = Tag_wr_en & (~Full | pop_ok) & ~byp_take;
    count_d = count_q;
    unique case (1'b1)
      push_ok & ~pop_ok: count_d = count_q + CNT_W_P'(1);
      pop_ok & ~push_ok: count_d = count_q - CNT_W_P'(1);
      default:           count_d = count_q;
    endcase
    ovf_d = ovf_q | (Tag_wr_en & Full & ~pop_ok);
    unf_d = unf_q | (Tag_rd_en & ~Tag_valid);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= TAG_W_P'(i);
      count_q <= CNT_W_P'(DEPTH);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok)
        mem_q[wr_ptr] <= Tag_in;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  tag_ptr_ctr #(.W(TAG_W_P)) u_rd_ptr (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (pop_ok),
    .cnt_o  (rd_ptr)
  );

  tag_ptr_ctr #(.W(TAG_W_P)) u_wr_ptr (
    .clk_i  (clock),
    .rst_ni (reset),
    .inc_i  (push_ok),
    .cnt_o  (wr_ptr)
  );
endmodule

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo with a queue-based pool model.
// Expected head tags are queued at drive time and compared at sample time.
module tb_tag_fifo;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Tag_rd_en = 1'b0;
  logic [4:0] Tag_out;
  logic       Tag_valid;
  logic       Tag_wr_en = 1'b0;
  logic [4:0] Tag_in = '0;
  logic       Full, Empty;
  logic [5:0] Count;
  logic       Ovf_err, Unf_err;

  int total = 0;
  int bad   = 0;

  bit [4:0]   pool [$];
  logic [4:0] exp_q [$];
  bit         m_ovf, m_unf;

  tag_fifo dut (
    .clock     (clock),
    .reset     (reset),
    .Tag_rd_en (Tag_rd_en),
    .Tag_out   (Tag_out),
    .Tag_valid (Tag_valid),
    .Tag_wr_en (Tag_wr_en),
    .Tag_in    (Tag_in),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Ovf_err   (Ovf_err),
    .Unf_err   (Unf_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  task automatic model_reset();
    pool.delete();
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      bit [4:0] v;
      v = i[4:0];
      pool.push_back(v);
    end
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input string t);
    int n;
    n = pool.size();
    chk({t, ".count"}, 32'(Count), 32'(n));
    chk({t, ".full"},  32'(Full),  32'(n == 32));
    chk({t, ".empty"}, 32'(Empty), 32'(n == 0));
    chk({t, ".ovf"},   32'(Ovf_err), 32'(m_ovf));
    chk({t, ".unf"},   32'(Unf_err), 32'(m_unf));
  endtask

  task automatic reset_consts(input string t);
    chk({t, ".tag"},   32'(Tag_out),   32'd0);
    chk({t, ".cnt"},   32'(Count),     32'd32);
    chk({t, ".full"},  32'(Full),      32'd1);
    chk({t, ".empty"}, 32'(Empty),     32'd0);
    chk({t, ".valid"}, 32'(Tag_valid), 32'd1);
    chk({t, ".ovf"},   32'(Ovf_err),   32'd0);
    chk({t, ".unf"},   32'(Unf_err),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    Tag_rd_en = 1'b0;
    Tag_wr_en = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    reset_consts("rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic step(input bit rd, input bit wr, input bit [4:0] tg,
                      input string t);
    bit empty, full, byp, valid, pop_ok, push_ok;
    bit [4:0] expo;
    @(negedge clock);
    Tag_rd_en = rd;
    Tag_wr_en = wr;
    Tag_in    = tg;
    empty = (pool.size() == 0);
    full  = (pool.size() == 32);
    byp   = 1'b0;
`ifdef TAG_FIFO_BYPASS_EN
    byp = empty && wr;
`endif
    valid = !empty || byp;
    expo  = byp ? tg : (empty ? 5'd0 : pool[0]);
    if (valid)
      exp_q.push_back(expo);
    #1;
    check_state(t);
    chk({t, ".valid"}, 32'(Tag_valid), 32'(valid));
    if (valid && exp_q.size() > 0)
      chk({t, ".tag"}, 32'(Tag_out), 32'(exp_q.pop_front()));
    pop_ok  = rd && !empty;
    push_ok = wr && (!full || pop_ok) && !(byp && rd);
    if (wr && full && !pop_ok) m_ovf = 1'b1;
    if (rd && !valid)          m_unf = 1'b1;
    if (pop_ok)  void'(pool.pop_front());
    if (push_ok) pool.push_back(tg);
  endtask

  initial begin
    model_reset();
    do_reset();

    // reset release, then three pops
    step(0, 0, 0, "t1");
    for (int i = 0; i < 3; i++) step(1, 0, 0, "t2pop");
    step(0, 0, 0, "t2idle");
    chk("t2.cnt29", 32'(Count), 32'd29);
    chk("t2.tag3",  32'(Tag_out), 32'd3);

    // push while full, then push+pop while full
    do_reset();
    step(0, 1, 5'd7, "t3push");
    step(0, 0, 0, "t3chk");
    chk("t3.ovf", 32'(Ovf_err), 32'd1);
    step(1, 1, 5'd9, "t3pp");
    for (int i = 0; i < 31; i++) step(1, 0, 0, "t3pop");
    step(0, 0, 0, "t3end");
    chk("t3.tag9", 32'(Tag_out), 32'd9);

    // drain and underflow
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 0, 0, "t4pop");
    step(0, 0, 0, "t4empty");
    chk("t4.valid0", 32'(Tag_valid), 32'd0);
    step(1, 0, 0, "t4unf");
    step(0, 0, 0, "t4after");
    chk("t4.unf", 32'(Unf_err), 32'd1);

    // empty with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 0, 0, "t5drain");
    step(1, 1, 5'd5, "t5pp");
    step(0, 0, 0, "t5next");
    step(0, 1, 5'd12, "t5push");
    step(1, 0, 0, "t5pop");
    step(0, 0, 0, "t5end");

    // wrap write pointer, then async reset mid-push
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, "t6pop");
    for (int i = 0; i < 4; i++) step(0, 1, 5'(20 + i), "t6push");
    @(negedge clock);
    Tag_wr_en = 1'b1;
    Tag_rd_en = 1'b1;
    Tag_in    = 5'd17;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    reset_consts("t6rst");
    @(negedge clock);
    Tag_wr_en = 1'b0;
    Tag_rd_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) step(1, 0, 0, "t6reinit");
    step(0, 0, 0, "t6end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
